// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared AXI channel types, FSM state codes and UART register offsets
package uart_arb_pkg;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARB     = 3'd1;
  localparam logic [2:0] POLL_AR = 3'd2;
  localparam logic [2:0] POLL_R  = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;
  typedef logic [2:0] state_t;
  localparam logic [3:0] TX_OFFSET_DEF   = 4'hC;
  localparam logic [3:0] STAT_OFFSET_DEF = 4'h4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'd2;
  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping modulo N
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic          found;
  logic [IW-1:0] idx;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_uart_tx_arbiter.sv
// axi_uart_tx_arbiter: round-robin funnel of byte streams into single-beat AXI writes to a UART TX register.
// Define UART_ARB_STATUS_POLL_EN to read the FIFO status register and wait for space before every write.
module axi_uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter logic [31:0] UART_BASE     = 32'h0,
  parameter logic [3:0]  TX_OFFSET     = TX_OFFSET_DEF,
  parameter logic [3:0]  STAT_OFFSET   = STAT_OFFSET_DEF,
  parameter int          TXF_SPACE_BIT = 16,
  parameter int          LOCK_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output s_axi_mosi_t          axi_mosi,
  input  s_axi_miso_t          axi_miso,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
`ifdef UART_ARB_STATUS_POLL_EN
  localparam state_t ISSUE = POLL_AR;
`else
  localparam state_t ISSUE = WRITE;
`endif
  state_t             state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d, lock_q, lock_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx, sel_idx, nxt_owner;
  logic [7:0]         sel_data;
  logic               take, aw_hs, w_hs, b_hs, unused;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid_i),
    .ptr(rr_q),
    .gnt(arb_gnt)
  );
  // a held packet lock overrides the round-robin pick
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (arb_gnt[i]) arb_idx = IW'(i);
    sel_idx  = lock_q ? owner_q : arb_idx;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) if (sel_idx == IW'(i)) sel_data = req_data_i[i*8 +: 8];
  end
  assign take      = lock_q ? req_valid_i[owner_q] : |arb_gnt;
  assign nxt_owner = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign aw_hs     = axi_mosi.awvalid & axi_miso.awready;
  assign w_hs      = axi_mosi.wvalid & axi_miso.wready;
  assign b_hs      = axi_mosi.bready & axi_miso.bvalid;
  assign unused    = ^{axi_miso, TXF_SPACE_BIT, STAT_OFFSET};
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    last_d    = last_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: state_d = ARB;
      ARB: begin
        if (take) begin
          owner_d = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          data_d  = sel_data;
          last_d  = req_last_i[sel_idx];
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (lock_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            lock_d = 1'b0;
            cnt_d  = '0;
            rr_d   = nxt_owner;
          end
        end
      end
`ifdef UART_ARB_STATUS_POLL_EN
      POLL_AR: state_d = axi_miso.arready ? POLL_R : POLL_AR;
      POLL_R: if (axi_miso.rvalid)
        state_d = (axi_miso.rresp == RESP_OKAY && axi_miso.rdata[TXF_SPACE_BIT]) ? WRITE : POLL_AR;
`endif
      WRITE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: if (b_hs) begin
        grant_d = '0;
        lock_d  = !last_q;
        rr_d    = last_q ? nxt_owner : rr_q;
        state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  always_comb begin
    axi_mosi         = '0;
    axi_mosi.awaddr  = UART_BASE + 32'(TX_OFFSET);
    axi_mosi.awsize  = SIZE_4B;
    axi_mosi.awburst = BURST_INCR;
    axi_mosi.awvalid = state_q == WRITE && !aw_done_q;
    axi_mosi.wdata   = {24'h0, data_q};
    axi_mosi.wstrb   = 4'b0001;
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = state_q == WRITE && !w_done_q;
    axi_mosi.bready  = state_q == RESP;
`ifdef UART_ARB_STATUS_POLL_EN
    axi_mosi.araddr  = UART_BASE + 32'(STAT_OFFSET);
    axi_mosi.arsize  = SIZE_4B;
    axi_mosi.arburst = BURST_INCR;
    axi_mosi.arvalid = state_q == POLL_AR;
    axi_mosi.rready  = state_q == POLL_R;
`endif
  end
  // ready is combinational so a requester can advance its byte on the same edge as the B handshake
  assign req_ready_o = (state_q == RESP && axi_miso.bvalid) ? grant_q : '0;
  assign grant_o     = grant_q;
`ifdef UART_ARB_STATUS_POLL_EN
  assign err_o = (state_q == RESP && axi_miso.bvalid && axi_miso.bresp != RESP_OKAY) ||
                 (state_q == POLL_R && axi_miso.rvalid && axi_miso.rresp != RESP_OKAY);
`else
  assign err_o = state_q == RESP && axi_miso.bvalid && axi_miso.bresp != RESP_OKAY;
`endif
endmodule

// File: tb/tb_axi_uart_tx_arbiter.sv
// tb_axi_uart_tx_arbiter: directed vectors against a behavioural AXI slave and byte-queue requesters
module tb_axi_uart_tx_arbiter;
  import uart_arb_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [31:0] req_data_i;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;
  logic        err_o;
  int          checks = 0, errors = 0;
  logic [8:0]  pkt [4][16];
  int          head [4], len [4];
  logic [7:0]  wlog [$];
  int          rlog [$];
  int          aw_wait = 0, aw_cyc = 0, aw_cnt = 0, ar_cnt = 0, rd_cnt = 0;
  int          stat_busy = 0, err_cnt = 0, multi = 0;
  logic [31:0] aw_addr = '0, ar_addr = '0;
  logic        bad_b = 1'b0;

  axi_uart_tx_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .axi_mosi(axi_mosi),
    .axi_miso(axi_miso),
    .grant_o(grant_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req_valid_i[i] = head[i] < len[i];
      if (head[i] < len[i]) begin
        req_data_i[i*8 +: 8] = pkt[i][head[i]][7:0];
        req_last_i[i]        = pkt[i][head[i]][8];
      end
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    pkt[r][len[r]] = {last, d};
    len[r]++;
    drive_reqs();
  endtask

  task automatic clear_logs();
    wlog.delete();
    rlog.delete();
    aw_cnt  = 0;
    aw_cyc  = 0;
    err_cnt = 0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    int k = 0;
    while (rlog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #2;
    chk(tag, rlog.size(), n);
  endtask

  task automatic wait_aw(input string tag, input int budget);
    int k = 0;
    while (!axi_mosi.awvalid && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk(tag, axi_mosi.awvalid, 1);
  endtask

  // AXI slave: responses set on the falling edge, handshakes logged once they have settled
  always @(negedge clk) begin
    axi_miso.awready = axi_mosi.awvalid && aw_wait == 0;
    if (axi_mosi.awvalid && aw_wait > 0) aw_wait--;
    axi_miso.wready  = axi_mosi.wvalid;
    axi_miso.bvalid  = axi_mosi.bready;
    axi_miso.bresp   = bad_b ? RESP_SLVERR : RESP_OKAY;
    axi_miso.arready = axi_mosi.arvalid;
    axi_miso.rvalid  = axi_mosi.rready;
    axi_miso.rresp   = RESP_OKAY;
    axi_miso.rdata   = (rd_cnt < stat_busy) ? 32'h0 : 32'h0001_0000;
    #1;
    if (axi_mosi.awvalid) aw_cyc++;
    if (axi_mosi.awvalid && axi_miso.awready) begin
      aw_cnt++;
      aw_addr = axi_mosi.awaddr;
    end
    if (axi_mosi.wvalid && axi_miso.wready) wlog.push_back(axi_mosi.wdata[7:0]);
    if (axi_mosi.arvalid && axi_miso.arready) begin
      ar_cnt++;
      ar_addr = axi_mosi.araddr;
    end
    if (axi_mosi.rready && axi_miso.rvalid) rd_cnt++;
    if (axi_mosi.bready && axi_miso.bvalid) bad_b = 1'b0;
    if (err_o) err_cnt++;
    if (req_ready_o != 4'b0) begin
      if ($countones(req_ready_o) != 1) multi++;
      for (int i = 0; i < 4; i++) if (req_ready_o[i]) begin
        rlog.push_back(i);
        head[i]++;
      end
      drive_reqs();
    end
  end

  initial begin
    rst = 1'b0;
    axi_miso = '0;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_awvalid", axi_mosi.awvalid, 0);
    chk("rst_wvalid", axi_mosi.wvalid, 0);
    chk("rst_bready", axi_mosi.bready, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    rst = 1'b1;
    // two single-byte packets, pointer at 0
    clear_logs();
    push(0, 1'b1, 8'h41);
    push(2, 1'b1, 8'h42);
    wait_pulses("rr_pulses", 2, 60);
    chk("rr_first_owner", rlog[0], 0);
    chk("rr_second_owner", rlog[1], 2);
    chk("rr_first_byte", wlog[0], 8'h41);
    chk("rr_second_byte", wlog[1], 8'h42);
    chk("rr_awaddr", aw_addr, 32'hC);
    // three-byte packet from req1 keeps req0 waiting
    clear_logs();
    push(1, 1'b0, 8'h10);
    push(1, 1'b0, 8'h11);
    push(1, 1'b1, 8'h12);
    wait_pulses("lock_first", 1, 40);
    push(0, 1'b1, 8'h20);
    wait_pulses("lock_pulses", 4, 80);
    chk("lock_owner1", rlog[1], 1);
    chk("lock_owner2", rlog[2], 1);
    chk("lock_owner3", rlog[3], 0);
    chk("lock_byte3", wlog[2], 8'h12);
    chk("lock_byte4", wlog[3], 8'h20);
    // req1 stalls mid-packet; lock must time out before req3 is served
    clear_logs();
    push(1, 1'b0, 8'h30);
    wait_pulses("tmo_first", 1, 40);
    push(3, 1'b1, 8'h33);
    repeat (240) @(negedge clk);
    #2;
    chk("tmo_still_locked", rlog.size(), 1);
    chk("tmo_no_grant", grant_o, 0);
    wait_pulses("tmo_released", 2, 100);
    chk("tmo_owner", rlog[1], 3);
    chk("tmo_byte", wlog[1], 8'h33);
    // AW delayed 5 cycles, W immediate; input byte changed after grant
    clear_logs();
    aw_wait = 5;
    push(2, 1'b1, 8'h55);
    wait_aw("slow_aw_seen", 20);
    chk("slow_grant", grant_o, 4'b0100);
    req_data_i[23:16] = 8'hEE;
    wait_pulses("slow_pulse", 1, 40);
    repeat (10) @(negedge clk);
    #2;
    chk("slow_one_pulse", rlog.size(), 1);
    chk("slow_aw_count", aw_cnt, 1);
    chk("slow_aw_cycles", aw_cyc, 6);
    chk("slow_w_count", wlog.size(), 1);
    chk("slow_latched_byte", wlog[0], 8'h55);
    // SLVERR on the first write only
    clear_logs();
    bad_b = 1'b1;
    push(0, 1'b1, 8'h60);
    push(1, 1'b1, 8'h61);
    wait_pulses("err_pulses", 2, 60);
    chk("err_count", err_cnt, 1);
    chk("err_owner0", rlog[0], 0);
    chk("err_owner1", rlog[1], 1);
    chk("err_byte1", wlog[1], 8'h61);
    // reset during a stalled write abandons it without a ready pulse
    clear_logs();
    aw_wait = 20;
    push(3, 1'b1, 8'h77);
    wait_aw("mid_aw_seen", 20);
    chk("mid_grant", grant_o, 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("mid_rst_awvalid", axi_mosi.awvalid, 0);
    chk("mid_rst_grant", grant_o, 0);
    chk("mid_rst_no_pulse", rlog.size(), 0);
    aw_wait = 0;
    rst = 1'b1;
    wait_pulses("mid_replay", 1, 40);
    chk("mid_owner", rlog[0], 3);
    chk("mid_aw_count", aw_cnt, 1);
    chk("mid_byte", wlog[wlog.size()-1], 8'h77);
`ifdef UART_ARB_STATUS_POLL_EN
    // FIFO full for three status reads
    clear_logs();
    ar_cnt = 0;
    rd_cnt = 0;
    stat_busy = 3;
    push(0, 1'b1, 8'h70);
    wait_pulses("poll_pulse", 1, 80);
    chk("poll_reads", ar_cnt, 4);
    chk("poll_araddr", ar_addr, 32'h4);
    chk("poll_writes", wlog.size(), 1);
    chk("poll_byte", wlog[0], 8'h70);
`endif
    chk("ready_onehot", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
